vec_mem_controller: RTL
=======================

VEC_MEM_CONTROLLER -- requirements
Module: vec_mem_controller

Interface
REQ-001 Parameter S, 32, scalar word and lane width in bits.
REQ-002 Parameter V, 192, vector width in bits; V SHALL be a multiple of S; LANES = V/S.
REQ-003 Parameters IMEM_BASE/IMEM_SIZE 0/1000, ROM_BASE/ROM_SIZE 1000/150000, RAM_BASE/RAM_SIZE 151000/150000, word-addressed region map.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pc  in  S  instruction fetch address; instruction  out  S  fetched word.
REQ-007 imem_addr  out  S  imem index; imem_data  in  S  combinational imem read data.
REQ-008 req_valid  in  1, req_ready  out  1, we  in  1, VecOp  in  1, address  in  S, wd  in  V: data request channel.
REQ-009 resp_valid  out  1, rd  out  V, err  out  1: response channel.
REQ-010 mem_sel  out  1 (0 ROM, 1 RAM), mem_en  out  1, mem_we  out  1, mem_addr  out  S, mem_wd  out  S: backing-memory beat port.
REQ-011 rom_rd  in  S, ram_rd  in  S: backing read data, valid one cycle after the mem_en beat.

Function
REQ-012 Fetch: imem_addr = pc - IMEM_BASE when pc in IMEM region, else 0; instruction SHALL register imem_data (pc in range) or 0, latency 1 cycle, independent of the data FSM.
REQ-013 Data FSM states IDLE, ACCESS, DRAIN, RESP; req_ready = 1 only in IDLE.
REQ-014 Request accepted on edge where req_valid & req_ready; address, we, VecOp, wd latched; IDLE->ACCESS.
REQ-015 Beat count n = LANES if VecOp else 1; beat i targets address+i, lane bits [i*S +: S].
REQ-016 Region select: whole range address..address+n-1 in ROM -> mem_sel 0; wholly in RAM -> mem_sel 1; mem_addr = address - base + i.
REQ-017 ACCESS issues one beat per cycle (mem_en=1), i = 0..n-1; after the last beat -> DRAIN.
REQ-018 Reads: lane i captured from selected rom_rd/ram_rd in the cycle after beat i; unused lanes of a scalar read SHALL be 0.
REQ-019 Writes: mem_we = 1 with mem_wd = lane i of wd; only to RAM.
REQ-020 DRAIN -> RESP after one cycle; RESP drives resp_valid = 1 for exactly one cycle, then -> IDLE.
REQ-021 Latency accept-edge to resp_valid: n+2 cycles (scalar 3, vector LANES+2); writes acknowledge with the same timing, rd = 0.
REQ-022 rd SHALL hold its value from RESP until the next RESP.
REQ-023 mem_en, mem_we = 0 outside ACCESS; mem_addr, mem_wd = 0 when mem_en = 0.
REQ-024 Range crossing a region boundary, lying in IMEM, or outside all regions, or a write to ROM: zero beats issued, ACCESS skipped (IDLE->DRAIN), rd = 0.

Reset
REQ-025 reset SHALL force IDLE immediately; req_ready=1 after release; resp_valid, err, mem_en, mem_we = 0; rd, instruction, mem_addr, mem_wd = 0.
REQ-026 Reset mid-ACCESS abandons remaining beats; no response is produced for the aborted request.

Configuration
REQ-027 Macro VEC_MEM_BOUNDS_CHECK_EN defined: REQ-024 cases assert err = 1 with resp_valid; otherwise err = 0.
REQ-028 Macro undefined: err tied 0; REQ-024 cases still issue no beats and return rd = 0 silently.

Structure
REQ-029 Shared package vec_mem_pkg: state enum, region enum {REG_NONE, REG_IMEM, REG_ROM, REG_RAM}, default region base/size constants.
REQ-030 One sub-module vec_mem_decode: combinational range-to-region classifier used for both fetch and data paths.

Verification
REQ-031 Scalar RAM write address 151010, wd lane0 0xDEADBEEF -> one beat mem_sel=1, mem_addr=10, mem_we=1; resp_valid 3 cycles after accept, err=0.
REQ-032 Vector ROM read address 1000, rom_rd = 0x100+mem_addr -> 6 beats mem_addr 0..5; rd lanes 0x100..0x105; resp_valid at cycle 8.
REQ-033 Vector read address 150998 (crosses ROM/RAM) -> no mem_en; resp_valid cycle 2 after accept, rd=0, err=1 with macro, 0 without.
REQ-034 Scalar write address 2000 (ROM) -> mem_we never asserted; err=1 with macro.
REQ-035 Assert reset on 3rd beat of vector RAM write -> mem_en=0 immediately, no resp_valid, req_ready=1 after release.
REQ-036 pc=5, imem_data=0x00A00093 -> instruction=0x00A00093 next cycle; pc=1200 -> instruction=0.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// Shared types and default region map for the vector memory controller.
// Word-addressed regions: IMEM, ROM, RAM.
package vec_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DRAIN,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_IMEM,
    REG_ROM,
    REG_RAM
  } region_t;

  localparam int DEF_IMEM_BASE = 0;
  localparam int DEF_IMEM_SIZE = 1000;
  localparam int DEF_ROM_BASE  = 1000;
  localparam int DEF_ROM_SIZE  = 150000;
  localparam int DEF_RAM_BASE  = 151000;
  localparam int DEF_RAM_SIZE  = 150000;

endpackage

// File: rtl/vec_mem_decode.sv
// Range-to-region classifier: the whole span lo..lo+cnt-1 must sit
// inside one region, otherwise REG_NONE. Offset is lo minus base.
module vec_mem_decode
  import vec_mem_pkg::*;
#(
  parameter int S         = 32,
  parameter int IMEM_BASE = DEF_IMEM_BASE,
  parameter int IMEM_SIZE = DEF_IMEM_SIZE,
  parameter int ROM_BASE  = DEF_ROM_BASE,
  parameter int ROM_SIZE  = DEF_ROM_SIZE,
  parameter int RAM_BASE  = DEF_RAM_BASE,
  parameter int RAM_SIZE  = DEF_RAM_SIZE
) (
  input  logic [S-1:0] lo,
  input  logic [S-1:0] cnt,
  output region_t      region,
  output logic [S-1:0] offset
);

  // Two guard bits keep lo-base underflow and
  // lo+cnt overflow from aliasing into a region.
  localparam int W = S + 2;

  logic [W-1:0] lo_w;
  logic [W-1:0] cnt_w;
  logic [W-1:0] off_i;
  logic [W-1:0] off_o;
  logic [W-1:0] off_r;

  assign lo_w  = W'(lo);
  assign cnt_w = W'(cnt);
  assign off_i = lo_w - W'(IMEM_BASE);
  assign off_o = lo_w - W'(ROM_BASE);
  assign off_r = lo_w - W'(RAM_BASE);

  function automatic logic fits(
    input logic [W-1:0] off,
    input logic [W-1:0] n,
    input int           size
  );
    return (off < W'(size)) &&
           (off + n <= W'(size));
  endfunction

  // Pick the single region that holds the full span
  always_comb begin
    region = REG_NONE;
    offset = '0;
    if (fits(off_i, cnt_w, IMEM_SIZE)) begin
      region = REG_IMEM;
      offset = off_i[S-1:0];
    end else if (fits(off_o, cnt_w, ROM_SIZE)) begin
      region = REG_ROM;
      offset = off_o[S-1:0];
    end else if (fits(off_r, cnt_w, RAM_SIZE)) begin
      region = REG_RAM;
      offset = off_r[S-1:0];
    end
  end

endmodule

// File: rtl/vec_mem_controller.sv
// Instruction fetch plus a beat-serialising vector data port.
// Define VEC_MEM_BOUNDS_CHECK_EN to report rejected requests on err.
module vec_mem_controller
  import vec_mem_pkg::*;
#(
  parameter int S         = 32,
  parameter int V         = 192,
  parameter int IMEM_BASE = DEF_IMEM_BASE,
  parameter int IMEM_SIZE = DEF_IMEM_SIZE,
  parameter int ROM_BASE  = DEF_ROM_BASE,
  parameter int ROM_SIZE  = DEF_ROM_SIZE,
  parameter int RAM_BASE  = DEF_RAM_BASE,
  parameter int RAM_SIZE  = DEF_RAM_SIZE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [S-1:0] pc,
  output logic [S-1:0] instruction,
  output logic [S-1:0] imem_addr,
  input  logic [S-1:0] imem_data,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         we,
  input  logic         VecOp,
  input  logic [S-1:0] address,
  input  logic [V-1:0] wd,
  output logic         resp_valid,
  output logic [V-1:0] rd,
  output logic         err,
  output logic         mem_sel,
  output logic         mem_en,
  output logic         mem_we,
  output logic [S-1:0] mem_addr,
  output logic [S-1:0] mem_wd,
  input  logic [S-1:0] rom_rd,
  input  logic [S-1:0] ram_rd
);

  localparam int LANES = V / S;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  region_t      f_region;
  logic [S-1:0] f_off;
  region_t      d_region;
  logic [S-1:0] d_off;
  logic [S-1:0] d_cnt;
  logic         ok_req;

  state_t        state;
  logic          we_q;
  logic          vec_q;
  logic          sel_q;
  logic [S-1:0]  off_q;
  logic [V-1:0]  wd_q;
  logic [IW-1:0] beat;
  logic          last;
  logic          cap_v;
  logic [IW-1:0] cap_idx;
  logic          cap_sel;
  logic [V-1:0]  acc;
  logic [V-1:0]  acc_nxt;

  vec_mem_decode #(
    .S(S),
    .IMEM_BASE(IMEM_BASE), .IMEM_SIZE(IMEM_SIZE),
    .ROM_BASE(ROM_BASE),   .ROM_SIZE(ROM_SIZE),
    .RAM_BASE(RAM_BASE),   .RAM_SIZE(RAM_SIZE)
  ) u_fetch_dec (
    .lo(pc),
    .cnt(S'(1)),
    .region(f_region),
    .offset(f_off)
  );

  assign d_cnt = VecOp ? S'(LANES) : S'(1);

  vec_mem_decode #(
    .S(S),
    .IMEM_BASE(IMEM_BASE), .IMEM_SIZE(IMEM_SIZE),
    .ROM_BASE(ROM_BASE),   .ROM_SIZE(ROM_SIZE),
    .RAM_BASE(RAM_BASE),   .RAM_SIZE(RAM_SIZE)
  ) u_data_dec (
    .lo(address),
    .cnt(d_cnt),
    .region(d_region),
    .offset(d_off)
  );

  assign imem_addr = (f_region == REG_IMEM) ? f_off : '0;

  // Fetch path: one-cycle registered instruction word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction <= '0;
    end else begin
      instruction <= (f_region == REG_IMEM) ?
                     imem_data : '0;
    end
  end

  // ROM takes reads only; RAM takes both
  assign ok_req = (d_region == REG_RAM) ||
                  ((d_region == REG_ROM) && !we);

  assign last = !vec_q || (beat == IW'(LANES - 1));

  assign req_ready = (state == IDLE);
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_sel   = mem_en && sel_q;
  assign mem_addr  = mem_en ? off_q + S'(beat) : '0;
  assign mem_wd    = mem_we ?
                     wd_q[int'(beat)*S +: S] : '0;

  // Merge the read beat returning this cycle into the lane buffer
  always_comb begin
    acc_nxt = acc;
    if (cap_v) begin
      acc_nxt[int'(cap_idx)*S +: S] =
        cap_sel ? ram_rd : rom_rd;
    end
  end

  // Data FSM: accept, stream beats, drain last read, respond
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      vec_q      <= 1'b0;
      sel_q      <= 1'b0;
      off_q      <= '0;
      wd_q       <= '0;
      beat       <= '0;
      cap_v      <= 1'b0;
      cap_idx    <= '0;
      cap_sel    <= 1'b0;
      acc        <= '0;
      rd         <= '0;
      resp_valid <= 1'b0;
    end else begin
      cap_v      <= 1'b0;
      resp_valid <= 1'b0;
      if (cap_v) acc <= acc_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q  <= we;
            vec_q <= VecOp;
            wd_q  <= wd;
            off_q <= d_off;
            sel_q <= (d_region == REG_RAM);
            beat  <= '0;
            acc   <= '0;
            state <= ok_req ? ACCESS : DRAIN;
          end
        end
        ACCESS: begin
          cap_v   <= !we_q;
          cap_idx <= beat;
          cap_sel <= sel_q;
          beat    <= beat + 1'b1;
          if (last) state <= DRAIN;
        end
        DRAIN: begin
          rd         <= acc_nxt;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef VEC_MEM_BOUNDS_CHECK_EN
  logic bad_q;

  // Remember rejected requests and flag them with the response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_q <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) bad_q <= !ok_req;
      err <= (state == DRAIN) && bad_q;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
